// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder
// Rate-controlled sample source for the FIR core input. Samples arrive on a
// valid/ready stream, are buffered in a small circular FIFO, and are released
// one per programmed period as a single-cycle enable strobe. A release slot
// that finds the FIFO empty produces a one-cycle underrun pulse instead.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | release stopped; period counter parked at 0, FIFO still fills
// ST_RUN   | period counter running; a tick releases one sample per period

module fir_sample_feeder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int DIV_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           div,
  output logic [WIDTH-1:0]           fir_sig,
  output logic                       fir_en,
  output logic                       underrun,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] period_m1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             tick;
  logic             slot_empty;

  // ---------------------------------------------------------------------------
  // FIFO status
  // ---------------------------------------------------------------------------

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Same index with opposite wrap bits means the writer has lapped the reader.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

  assign s_ready = !fifo_full;
  assign push    = s_valid && !fifo_full;

  // Pointer difference is exact occupancy thanks to the extra wrap bit.
  assign level = wr_ptr - rd_ptr;

  // Periods of 0 and 1 both collapse to "every cycle".
  assign period_m1 = (div < DIV_W'(2)) ? '0 : (div - DIV_W'(1));

  // ---------------------------------------------------------------------------
  // Release FSM
  // ---------------------------------------------------------------------------

  // State register and period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and next-count: enable is sampled every edge; leaving or
  // entering RUN always parks the counter at 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (enable) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (tick) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + DIV_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Release decode: >= rather than == so shrinking div mid-count fires at
  // once instead of waiting for the counter to wrap.
  always_comb begin
    tick       = 1'b0;
    pop        = 1'b0;
    slot_empty = 1'b0;
    if (state == ST_RUN && enable && (cnt >= period_m1)) begin
      tick = 1'b1;
    end
    // A sample pushed on this same edge is not yet visible to the tick.
    if (tick) begin
      pop        = !fifo_empty;
      slot_empty = fifo_empty;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------

  // Sample storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= s_data;
    end
  end

  // Read/write pointers; reset discards everything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------

  // Registered strobes and sample; fir_sig holds between releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_sig  <= '0;
      fir_en   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      fir_en   <= pop;
      underrun <= slot_empty;
      if (pop) begin
        fir_sig <= mem[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Testbench for fir_sample_feeder: a table of nominal-rate vectors, hand
// sequences for the multi-cycle corner cases, and a randomized run checked
// against a queue-based reference model.

module tb_fir_sample_feeder;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int DV = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic          enable;
  logic [DV-1:0] div;
  logic [W-1:0]  fir_sig;
  logic          fir_en;
  logic          underrun;
  logic [3:0]    level;

  fir_sample_feeder #(.WIDTH(W), .DEPTH(D), .DIV_W(DV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .enable   (enable),
    .div      (div),
    .fir_sig  (fir_sig),
    .fir_en   (fir_en),
    .underrun (underrun),
    .level    (level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a sample queue, a run flag and a count of cycles since
  // the last release slot.
  logic [W-1:0] mq[$];
  bit           m_run;
  int           m_phase;
  bit           m_en;
  bit           m_ur;
  logic [W-1:0] m_sig;

  task automatic model_reset();
    mq.delete();
    m_run   = 0;
    m_phase = 0;
    m_en    = 0;
    m_ur    = 0;
    m_sig   = '0;
  endtask

  task automatic model_step();
    int per;
    bit tick;
    bit acc;
    per  = (div < 2) ? 1 : int'(div);
    tick = m_run && enable && (m_phase >= per - 1);
    acc  = s_valid && (mq.size() < D);
    m_en = 0;
    m_ur = 0;
    if (tick) begin
      if (mq.size() > 0) begin
        m_en  = 1;
        m_sig = mq.pop_front();
      end else begin
        m_ur = 1;
      end
    end
    if (acc) mq.push_back(s_data);
    if (!m_run) begin
      m_run   = enable;
      m_phase = 0;
    end else if (!enable) begin
      m_run   = 0;
      m_phase = 0;
    end else if (tick) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  // One clock: update the model with the inputs in force, take the edge,
  // sample 1 ns later, optionally compare everything against the model.
  task automatic cycle(input bit mchk);
    model_step();
    @(posedge clk);
    #1;
    if (mchk) begin
      chk("m_fir_en",   fir_en,   m_en);
      chk("m_underrun", underrun, m_ur);
      chk("m_fir_sig",  fir_sig,  m_sig);
      chk("m_level",    level,    mq.size());
      chk("m_s_ready",  s_ready,  mq.size() < D);
    end
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear
  // before any edge arrives.
  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    enable  = 1'b0;
    div     = '0;
    #2;
    chk("rst_fir_sig",  fir_sig,  0);
    chk("rst_fir_en",   fir_en,   0);
    chk("rst_underrun", underrun, 0);
    chk("rst_level",    level,    0);
    chk("rst_s_ready",  s_ready,  1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_samples(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = W'(base + i);
      cycle(1);
    end
    s_valid = 1'b0;
  endtask

  typedef struct {
    bit            v;
    logic [W-1:0]  d;
    bit            en;
    logic [DV-1:0] dv;
    bit            e_en;
    logic [W-1:0]  e_sig;
    bit            e_ur;
    int            e_lvl;
  } vec_t;

  vec_t tbl[26];

  initial begin : main
    bit            was_ready;
    int            nxt;
    logic [W-1:0]  got[$];
    logic [5:0]    pat[2];
    int            rel;

    // Nominal rate table: five pushes while stopped, then enable with div=4.
    // Entry 5 is the edge that enters RUN; strobes follow every 4th edge.
    for (int i = 0; i < 5; i++) begin
      tbl[i].v     = 1;
      tbl[i].d     = W'(i + 1);
      tbl[i].en    = 0;
      tbl[i].dv    = 8'd4;
      tbl[i].e_en  = 0;
      tbl[i].e_sig = '0;
      tbl[i].e_ur  = 0;
      tbl[i].e_lvl = i + 1;
    end
    for (int j = 0; j <= 20; j++) begin
      rel = j / 4;
      tbl[5+j].v     = 0;
      tbl[5+j].d     = '0;
      tbl[5+j].en    = 1;
      tbl[5+j].dv    = 8'd4;
      tbl[5+j].e_en  = (j > 0) && (j % 4 == 0);
      tbl[5+j].e_sig = W'(rel);
      tbl[5+j].e_ur  = 0;
      tbl[5+j].e_lvl = 5 - rel;
    end

    do_reset();
    for (int k = 0; k < 26; k++) begin
      s_valid = tbl[k].v;
      s_data  = tbl[k].d;
      enable  = tbl[k].en;
      div     = tbl[k].dv;
      cycle(0);
      chk($sformatf("tbl%0d_fir_en", k),   fir_en,   tbl[k].e_en);
      chk($sformatf("tbl%0d_fir_sig", k),  fir_sig,  tbl[k].e_sig);
      chk($sformatf("tbl%0d_underrun", k), underrun, tbl[k].e_ur);
      chk($sformatf("tbl%0d_level", k),    level,    tbl[k].e_lvl);
    end

    // Backpressure: 10 offered while stopped, only 8 fit.
    do_reset();
    div = 8'd1;
    nxt = 1;
    for (int c = 0; c < 10; c++) begin
      s_valid   = 1'b1;
      s_data    = W'(nxt);
      was_ready = s_ready;
      cycle(1);
      if (was_ready) nxt++;
    end
    chk("bp_accepted", nxt - 1, 8);
    chk("bp_level",    level,   8);
    chk("bp_s_ready",  s_ready, 0);
    enable = 1'b1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      s_valid   = (nxt <= 10);
      s_data    = W'(nxt);
      was_ready = s_ready;
      cycle(1);
      if (s_valid && was_ready) nxt++;
      if (fir_en) got.push_back(fir_sig);
    end
    s_valid = 1'b0;
    chk("bp_released", got.size(), 10);
    for (int i = 0; i < got.size(); i++) chk($sformatf("bp_order%0d", i), got[i], i + 1);

    // Underrun with div=3, then a push on the tick cycle released one period later.
    do_reset();
    div    = 8'd3;
    enable = 1'b1;
    cycle(1);
    for (int j = 1; j <= 9; j++) begin
      if (j == 6) begin
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
      end
      cycle(1);
      s_valid = 1'b0;
      if (j == 3 || j == 6) begin
        chk("ur_pulse",   underrun, 1);
        chk("ur_fir_en",  fir_en,   0);
        chk("ur_fir_sig", fir_sig,  0);
      end
      if (j == 6) chk("ur_level", level, 1);
      if (j == 9) begin
        chk("ur_late_en",  fir_en,   1);
        chk("ur_late_sig", fir_sig,  16'hBEEF);
        chk("ur_late_ur",  underrun, 0);
      end
    end

    // Div shrink mid-count, then stop on the slot cycle.
    do_reset();
    push_samples(2, 16'h11);
    div    = 8'd10;
    enable = 1'b1;
    cycle(1);
    for (int j = 1; j <= 6; j++) cycle(1);
    div = 8'd2;
    cycle(1);
    chk("dc_tick_en",  fir_en,  1);
    chk("dc_tick_sig", fir_sig, 16'h11);
    cycle(1);
    enable = 1'b0;
    cycle(1);
    chk("dc_stop_en",    fir_en, 0);
    chk("dc_stop_level", level,  1);
    for (int j = 0; j < 5; j++) cycle(1);
    chk("dc_retained", level, 1);

    // div=0 and div=1 must give the same back-to-back strobe train.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      push_samples(4, 16'h40);
      div    = DV'(r);
      enable = 1'b1;
      cycle(1);
      pat[r] = '0;
      for (int j = 0; j < 6; j++) begin
        cycle(1);
        pat[r][5-j] = fir_en;
      end
      chk($sformatf("div%0d_train", r), pat[r], 6'b111100);
    end
    chk("div01_equal", pat[0], pat[1]);

    // Reset mid-stream with five samples queued and release active.
    do_reset();
    push_samples(5, 16'h70);
    chk("mr_level5", level, 5);
    div    = 8'd4;
    enable = 1'b1;
    for (int j = 0; j < 5; j++) cycle(1);
    chk("mr_pre_en", fir_en, 1);
    do_reset();
    enable = 1'b1;
    div    = 8'd1;
    for (int j = 0; j < 4; j++) begin
      cycle(1);
      chk("mr_no_en", fir_en, 0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      s_valid = ($urandom_range(0, 99) < 55);
      s_data  = W'($urandom);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 99) < 4)  div = DV'($urandom_range(0, 6));
      cycle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
